// File: rtl/data_memory_responder.sv
// data_memory_responder: responder side of a word-wide data-memory load/store
// interface. Accepts one request at a time over a valid/ready channel, waits
// WAIT_CYCLES extra cycles, commits the access, then holds a response until the
// requester takes it. Misaligned or out-of-range accesses return an error.
module data_memory_responder #(
   parameter int          DEPTH_WORDS = 256,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_arst,
   input  logic        i_reqValid,
   output logic        o_reqReady,
   input  logic        i_reqWrite,
   input  logic [31:0] i_reqAddress,
   input  logic [31:0] i_reqWriteData,
   input  logic [3:0]  i_reqByteEn,
   output logic        o_rspValid,
   input  logic        i_rspReady,
   output logic [31:0] o_rspReadData,
   output logic        o_rspError
);

   localparam int          AW         = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN_BYTES = 32'(4 * DEPTH_WORDS);
   localparam logic [3:0]  WAIT_LOAD  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESPOND
   } state_t;

   state_t      state;
   logic [3:0]  wait_cnt;

   // Request captured at acceptance; used when the commit happens later.
   logic        cap_write;
   logic [31:0] cap_addr;
   logic [31:0] cap_data;
   logic [3:0]  cap_be;

   logic [31:0] mem [DEPTH_WORDS];

   // Commit view: the access that is applied on the edge entering RESPOND.
   logic        accept;
   logic        commit_en;
   logic        c_write;
   logic [31:0] c_addr;
   logic [31:0] c_data;
   logic [3:0]  c_be;
   logic [31:0] c_offset;
   logic        c_err;
   logic [AW-1:0] c_index;
   logic [31:0] c_read_word;

   assign accept = (state == ST_IDLE) && o_reqReady && i_reqValid;

   // Select which access commits this cycle: the live request when there is no
   // wait stage, otherwise the captured request on the last wait cycle.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      commit_en = 1'b0;
      c_write   = cap_write;
      c_addr    = cap_addr;
      c_data    = cap_data;
      c_be      = cap_be;
      if (state == ST_WAIT && wait_cnt == 4'd0) begin
         commit_en = 1'b1;
      end else if (accept && WAIT_CYCLES == 0) begin
         commit_en = 1'b1;
         c_write   = i_reqWrite;
         c_addr    = i_reqAddress;
         c_data    = i_reqWriteData;
         c_be      = i_reqByteEn;
      end
   end

   // Address decode relative to BASE_ADDR; unsigned wrap below the base is
   // caught by the explicit lower-bound compare.
   assign c_offset = c_addr - BASE_ADDR;
   assign c_err    = (c_addr[1:0] != 2'b00) || (c_addr < BASE_ADDR) ||
                     (c_offset >= SPAN_BYTES);
   assign c_index  = c_offset[AW+1:2];

   // Load data for the response; stores and errors return zero.
   always_comb begin
      c_read_word = 32'd0;
      if (!c_write && !c_err) begin
         c_read_word = mem[c_index];
      end
   end

   // Storage array with per-lane write enables, written only at commit.
   // NOTE: the array has no reset; its contents are meant to persist across
   // reset, and leaving it out of the reset lets it map onto RAM.
   always_ff @(posedge i_clk) begin
      if (commit_en && c_write && !c_err) begin
         for (int n = 0; n < 4; n++) begin
            if (c_be[n]) begin
               mem[c_index][8*n +: 8] <= c_data[8*n +: 8];
            end
         end
      end
   end

   // Transaction FSM with registered handshake and response outputs.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples values from before the edge.
         state         <= ST_IDLE;
         wait_cnt      <= 4'd0;
         o_reqReady    <= 1'b0;
         o_rspValid    <= 1'b0;
         o_rspReadData <= 32'd0;
         o_rspError    <= 1'b0;
         cap_write     <= 1'b0;
         cap_addr      <= 32'd0;
         cap_data      <= 32'd0;
         cap_be        <= 4'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               o_reqReady <= 1'b1;
               if (accept) begin
                  o_reqReady <= 1'b0;
                  cap_write  <= i_reqWrite;
                  cap_addr   <= i_reqAddress;
                  cap_data   <= i_reqWriteData;
                  cap_be     <= i_reqByteEn;
                  if (WAIT_CYCLES > 0) begin
                     state    <= ST_WAIT;
                     wait_cnt <= WAIT_LOAD;
                  end else begin
                     state         <= ST_RESPOND;
                     o_rspValid    <= 1'b1;
                     o_rspReadData <= c_read_word;
                     o_rspError    <= c_err;
                  end
               end
            end
            ST_WAIT: begin
               if (wait_cnt == 4'd0) begin
                  state         <= ST_RESPOND;
                  o_rspValid    <= 1'b1;
                  o_rspReadData <= c_read_word;
                  o_rspError    <= c_err;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            ST_RESPOND: begin
               if (i_rspReady) begin
                  state         <= ST_IDLE;
                  o_rspValid    <= 1'b0;
                  o_rspReadData <= 32'd0;
                  o_rspError    <= 1'b0;
                  o_reqReady    <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
